// File: rtl/matmul_host_driver.sv
// Host-side driver for the 2x2 systolic matmul tile: tracks the tile's 12-cycle frame, feeds it, decodes results.
// Optional macro REF_CHECK_EN adds an internal mod-256 reference product and the res_mismatch output.
module matmul_host_driver #(
  parameter logic [15:0] DUMMY_MAT  = 16'h1001,
  parameter int          SYNC_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [15:0]           cmd_a,
  input  logic [15:0]           cmd_b,
  output logic                  cmd_err,
  output logic [7:0]            acc_ui,
  output logic [7:0]            acc_uio,
  input  logic [7:0]            acc_uo,
  input  logic [7:0]            acc_uio_out,
  input  logic [7:0]            acc_uio_oe,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_c,
  output logic                  res_ovf,
`ifdef REF_CHECK_EN
  output logic                  res_mismatch,
`endif
  output logic [SYNC_CNT_W-1:0] sync_cnt
);

  localparam logic [3:0] P_LAST = 4'd11;

  logic [3:0]            p_q, p_d;
  logic [7:0]            ui_q, ui_d, uio_q, uio_d;
  logic [15:0]           b_q, b_d;
  logic                  frame_real_q, frame_real_d;
  logic                  carry_real_q, carry_real_d;
  logic [15:0]           row0_q, row0_d;
  logic [31:0]           res_c_q, res_c_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  oe_full_q;
  logic [SYNC_CNT_W-1:0] sync_q, sync_d;

  logic        oe_full, resync, wrap, accept, zero_row, load_real, publish;
  logic [15:0] row_pins;

`ifdef REF_CHECK_EN
  logic [15:0] a_q, a_d;
  logic [31:0] ref_q, ref_d;
  logic        mismatch_q, mismatch_d;

  function automatic logic [31:0] mat_mul(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] x [4];
    logic [7:0] y [4];
    for (int i = 0; i < 4; i++) begin
      x[i] = {4'd0, a[15-4*i -: 4]};
      y[i] = {4'd0, b[15-4*i -: 4]};
    end
    mat_mul = {x[0]*y[0] + x[1]*y[2], x[0]*y[1] + x[1]*y[3],
               x[2]*y[0] + x[3]*y[2], x[2]*y[1] + x[3]*y[3]};
  endfunction
`endif

  assign oe_full   = (acc_uio_oe == 8'hFF);
  // A rising oe outside p=11 means the tile's frame has slipped; treat that edge as p=11.
  assign resync    = oe_full && !oe_full_q && (p_q != P_LAST);
  assign wrap      = (p_q == P_LAST) || resync;
  assign cmd_ready = (p_q == P_LAST) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign zero_row  = (cmd_a[15:8] == 8'd0) || (cmd_a[7:0] == 8'd0) ||
                     (cmd_b[15:8] == 8'd0) || (cmd_b[7:0] == 8'd0);
  assign load_real = accept && !zero_row;
  assign publish   = (p_q == 4'd0) && carry_real_q && !resync;
  assign row_pins  = {acc_uio_out[7:4], acc_uo[7:4], acc_uio_out[3:0], acc_uo[3:0]};

  always_comb begin
    p_d          = wrap ? 4'd0 : p_q + 4'd1;
    ui_d         = ui_q;
    uio_d        = uio_q;
    b_d          = b_q;
    frame_real_d = frame_real_q;
    carry_real_d = carry_real_q;
    row0_d       = row0_q;
    res_c_d      = res_c_q;
    res_valid_d  = res_valid_q;
    res_ovf_d    = res_ovf_q;
    cmd_err_d    = accept && zero_row;
    sync_d       = sync_q;
`ifdef REF_CHECK_EN
    a_d          = a_q;
    ref_d        = ref_q;
    mismatch_d   = mismatch_q;
`endif

    if (p_q == 4'd3) begin
      ui_d  = b_q[15:8];
      uio_d = b_q[7:0];
    end

    if (wrap) begin
      carry_real_d = frame_real_q && !resync;
      if (oe_full) row0_d = row_pins;
`ifdef REF_CHECK_EN
      ref_d = mat_mul(a_q, b_q);
`endif
      if (load_real) begin
        ui_d         = cmd_a[15:8];
        uio_d        = cmd_a[7:0];
        b_d          = cmd_b;
        frame_real_d = 1'b1;
`ifdef REF_CHECK_EN
        a_d          = cmd_a;
`endif
      end else begin
        ui_d         = DUMMY_MAT[15:8];
        uio_d        = DUMMY_MAT[7:0];
        b_d          = DUMMY_MAT;
        frame_real_d = 1'b0;
`ifdef REF_CHECK_EN
        a_d          = DUMMY_MAT;
`endif
      end
    end

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    if (publish) begin
      if (!res_valid_q || res_ready) begin
        res_c_d     = {row0_q, row_pins};
        res_valid_d = 1'b1;
`ifdef REF_CHECK_EN
        mismatch_d  = ({row0_q, row_pins} != ref_q);
`endif
      end else begin
        res_ovf_d = 1'b1;
      end
    end

    if (resync && (sync_q != {SYNC_CNT_W{1'b1}})) sync_d = sync_q + SYNC_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q          <= 4'd0;
      ui_q         <= DUMMY_MAT[15:8];
      uio_q        <= DUMMY_MAT[7:0];
      b_q          <= DUMMY_MAT;
      frame_real_q <= 1'b0;
      carry_real_q <= 1'b0;
      row0_q       <= 16'd0;
      res_c_q      <= 32'd0;
      res_valid_q  <= 1'b0;
      res_ovf_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      oe_full_q    <= 1'b0;
      sync_q       <= '0;
`ifdef REF_CHECK_EN
      a_q          <= DUMMY_MAT;
      ref_q        <= 32'd0;
      mismatch_q   <= 1'b0;
`endif
    end else begin
      p_q          <= p_d;
      ui_q         <= ui_d;
      uio_q        <= uio_d;
      b_q          <= b_d;
      frame_real_q <= frame_real_d;
      carry_real_q <= carry_real_d;
      row0_q       <= row0_d;
      res_c_q      <= res_c_d;
      res_valid_q  <= res_valid_d;
      res_ovf_q    <= res_ovf_d;
      cmd_err_q    <= cmd_err_d;
      oe_full_q    <= oe_full;
      sync_q       <= sync_d;
`ifdef REF_CHECK_EN
      a_q          <= a_d;
      ref_q        <= ref_d;
      mismatch_q   <= mismatch_d;
`endif
    end
  end

  assign acc_ui    = ui_q;
  assign acc_uio   = uio_q;
  assign cmd_err   = cmd_err_q;
  assign res_valid = res_valid_q;
  assign res_c     = res_c_q;
  assign res_ovf   = res_ovf_q;
  assign sync_cnt  = sync_q;
`ifdef REF_CHECK_EN
  assign res_mismatch = mismatch_q;
`endif

endmodule

// File: doc/matmul_host_driver.md
Name: matmul_host_driver

Overview:
- Host-side companion to the 2x2 systolic matmul tile; drives the tile's ui_in/uio_in pins and decodes its uo_out/uio_out/uio_oe result stream.
- The tile has no handshake. It runs a fixed 12-cycle frame: sample A, sample B, compute, emit two result rows.
- This block tracks that frame with a phase counter and presents a valid/ready command port and a valid/ready result port to the rest of the design.
- It never lets the tile stall: it keeps the tile fed with a dummy matrix when idle and rejects commands containing an all-zero row.

Parameters:
- DUMMY_MAT, 16'h1001, matrix driven when no command is loaded (identity); [15:8] to ui_in, [7:0] to uio_in.
- SYNC_CNT_W, 8, width of the saturating resync-event counter.

Ports:
- clk  in  1  clock, shared with the tile
- rst  in  1  asynchronous reset, active-high; the tile's rst_n is driven from ~rst
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_a  in  16  {A00,A01,A10,A11}, 4-bit nibbles, MSB first
- cmd_b  in  16  {B00,B01,B10,B11}, same packing
- cmd_err  out  1  one-cycle pulse: accepted command rejected (zero row)
- acc_ui  out  8  to tile ui_in
- acc_uio  out  8  to tile uio_in
- acc_uo  in  8  from tile uo_out
- acc_uio_out  in  8  from tile uio_out
- acc_uio_oe  in  8  from tile uio_oe
- res_valid  out  1  result held
- res_ready  in  1  result consumed when res_valid && res_ready
- res_c  out  32  {C00,C01,C10,C11}, 8 bits each
- res_ovf  out  1  sticky; a real result was dropped because res_valid was still high
- sync_cnt  out  SYNC_CNT_W  saturating count of resync events

Behaviour:
- Phase counter p, 0..11, wraps 11->0. It is reset to 0, aligned so the tile's IDLE executes at the edge ending p=11 (true for a shared reset).
- Pin drive: all pin outputs are registered.
  - p=0..3: acc_ui/acc_uio carry the frame's A.
  - p=4..11: they carry the frame's B.
  - The tile samples A at the edge ending p=1 and B at the edge ending p=4.
- Frame contents are loaded at the edge ending p=11:
  - If a command is accepted, A and B come from it and frame_real=1.
  - Otherwise both A and B are DUMMY_MAT and frame_real=0.
- cmd_ready is high only in p=11 while not in reset.
- Zero-row check: a command whose A or B has {X00,X01}==0 or {X10,X11}==0 is still accepted (handshake completes), but:
  - cmd_err pulses the next cycle;
  - the frame is sent as dummy with frame_real=0.
- Result capture, decoded as Cx0={uio[7:4],uo[7:4]} and Cx1={uio[3:0],uo[3:0]}:
  - Row 0 (C00,C01) is captured at the edge ending p=11, if acc_uio_oe==8'hFF.
  - Row 1 (C10,C11) is captured at the edge ending p=0.
  - These rows belong to the frame launched in the preceding p=0..11; the frame_real bit is carried one frame.
- Publish: at the edge ending p=0, if the carried frame_real=1:
  - if res_valid=0, load res_c and set res_valid;
  - if res_valid=1, keep the old result and set res_ovf.
  - res_valid clears on handshake.
  - A simultaneous handshake and publish loads the new result (res_valid stays 1).
- Arithmetic: the tile's C is 8 bits, i.e. the sum mod 256. This block reports the pins verbatim.
- Resync: a rising edge of acc_uio_oe (previous value != 8'hFF, current == 8'hFF) observed when p != 11:
  - p is forced to 0 next cycle (the edge is treated as p=11);
  - the carried frame_real is cleared, so a misaligned result is never published;
  - the current frame is re-sent as dummy;
  - sync_cnt increments, saturating.
- Reset values: p=0, pins=DUMMY_MAT, frame_real=0, cmd_ready=0, cmd_err=0, res_valid=0, res_c=0, res_ovf=0, sync_cnt=0.
- Reset mid-frame discards everything in flight.

Optional Feature:
- REF_CHECK_EN.
- Defined:
  - the block computes the mod-256 2x2 product of each real frame internally;
  - extra output res_mismatch (1 bit) is valid with res_valid and is 1 if res_c differs from the computed product.
- Undefined: no res_mismatch port, no multipliers.

Test Plan:
- Shared reset released, cmd_a=16'h1234, cmd_b=16'h5678 offered at p=11 -> res_valid with res_c=32'h13162B32, 13 cycles after acceptance; res_ovf=0.
- cmd_a=cmd_b=16'hFFFF -> res_c=32'hC2C2C2C2 (450 mod 256); with REF_CHECK_EN, res_mismatch=0.
- cmd_a=16'h0012 -> cmd_err pulse one cycle after acceptance, no res_valid, and the next frame's 16'h1234 x 16'h5678 still correct.
- res_ready held 0, two real commands back-to-back -> first result retained, res_ovf=1; then res_ready=1 -> res_valid drops.
- No commands for 5 frames -> pins alternate DUMMY_MAT only, no res_valid; the tile keeps emitting acc_uio_oe=8'hFF at each p=11.
- Pulse the tile's reset alone mid-frame -> sync_cnt=1 after realignment; the next command returns the correct product.
